// File: rtl/fifo_pkt_wr_ctrl.sv
// Write-side pointer controller for a packet FIFO. A speculative write pointer
// follows the packet in flight, and a committed pointer marks the last good
// packet boundary. Only the committed pointer is exported to the reader, in Gray
// code. Bad packets and mid-packet overflow rewind the speculative pointer.
module fifo_pkt_wr_ctrl #(
  parameter int ADDR_WIDTH   = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int DROP_ON_FULL = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  input  logic                  s_last,
  input  logic                  s_user,
  output logic                  s_ready,
  input  logic [ADDR_WIDTH:0]   af_thresh,
  input  logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH:0]   w_ptr_gray,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  pkt_commit,
  output logic                  pkt_drop,
  output logic [CNT_WIDTH-1:0]  drop_cnt
);

  localparam int            PW    = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH = PW'(1) << ADDR_WIDTH;
  localparam bit            DOF   = (DROP_ON_FULL != 0);

  typedef enum logic [1:0] {IDLE, PKT, DISCARD} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] wr_bin, wr_nxt;
  logic [PW-1:0] cmt_bin, cmt_nxt;
  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] rd_bin;
  logic [PW-1:0] free;
  logic          accept;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Bring the reader's Gray pointer into the write clock domain.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= rd_ptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign rd_bin = gray2bin(sync_q[SYNC_STAGES-1]);
  assign level  = wr_bin - rd_bin;
  assign full   = (level == DEPTH);
  assign free   = DEPTH - level;

  assign s_ready = !full || (state == DISCARD) || ((state == PKT) && DOF);
  assign accept  = s_valid && s_ready;
  assign mem_we  = accept && !full && (state != DISCARD);
  assign w_addr  = wr_bin[ADDR_WIDTH-1:0];

  // Packet FSM: advance the speculative pointer, commit or rewind at packet end.
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    state_nxt  = state;
    wr_nxt     = wr_bin;
    cmt_nxt    = cmt_bin;
    pkt_commit = 1'b0;
    pkt_drop   = 1'b0;
    if (mem_we) begin
      wr_nxt = wr_bin + 1'b1;
      if (!s_last) begin
        state_nxt = PKT;
      end else if (!s_user) begin
        cmt_nxt    = wr_bin + 1'b1;
        pkt_commit = 1'b1;
        state_nxt  = IDLE;
      end else begin
        wr_nxt    = cmt_bin;
        pkt_drop  = 1'b1;
        state_nxt = IDLE;
      end
    end else if ((state == PKT) && DOF && s_valid && full) begin
      // Overflowing word is swallowed; the rest of the packet is discarded.
      wr_nxt    = cmt_bin;
      pkt_drop  = 1'b1;
      state_nxt = s_last ? IDLE : DISCARD;
    end else if ((state == DISCARD) && accept && s_last) begin
      state_nxt = IDLE;
    end
  end

  // Pointer, state, status and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wr_bin      <= '0;
      cmt_bin     <= '0;
      w_ptr_gray  <= '0;
      almost_full <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      wr_bin      <= wr_nxt;
      cmt_bin     <= cmt_nxt;
      // Encoded from the next committed value so the commit shows one cycle after accept.
      w_ptr_gray  <= cmt_nxt ^ (cmt_nxt >> 1);
      almost_full <= (free <= af_thresh);
      if (pkt_drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_pkt_wr_ctrl.sv
// Bench for fifo_pkt_wr_ctrl: one instance backpressures on full, one drops.
// Both see the same stimulus. A behavioural model of each is checked every cycle.
module tb_fifo_pkt_wr_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_valid = 1'b0, s_last = 1'b0, s_user = 1'b0;
  logic [4:0] af_thresh = 5'd0;
  logic [4:0] rd_ptr_gray = 5'd0;

  logic        s_ready0, mem_we0, full0, almost_full0, pkt_commit0, pkt_drop0;
  logic [3:0]  w_addr0;
  logic [4:0]  w_ptr_gray0, level0;
  logic [15:0] drop_cnt0;
  logic        s_ready1, mem_we1, full1, almost_full1, pkt_commit1, pkt_drop1;
  logic [3:0]  w_addr1;
  logic [4:0]  w_ptr_gray1, level1;
  logic [15:0] drop_cnt1;

  fifo_pkt_wr_ctrl #(.ADDR_WIDTH(4), .SYNC_STAGES(2), .DROP_ON_FULL(0), .CNT_WIDTH(16)) dut0 (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_last(s_last), .s_user(s_user),
    .s_ready(s_ready0), .af_thresh(af_thresh), .rd_ptr_gray(rd_ptr_gray),
    .mem_we(mem_we0), .w_addr(w_addr0), .w_ptr_gray(w_ptr_gray0), .full(full0),
    .almost_full(almost_full0), .level(level0), .pkt_commit(pkt_commit0),
    .pkt_drop(pkt_drop0), .drop_cnt(drop_cnt0));

  fifo_pkt_wr_ctrl #(.ADDR_WIDTH(4), .SYNC_STAGES(2), .DROP_ON_FULL(1), .CNT_WIDTH(16)) dut1 (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_last(s_last), .s_user(s_user),
    .s_ready(s_ready1), .af_thresh(af_thresh), .rd_ptr_gray(rd_ptr_gray),
    .mem_we(mem_we1), .w_addr(w_addr1), .w_ptr_gray(w_ptr_gray1), .full(full1),
    .almost_full(almost_full1), .level(level1), .pkt_commit(pkt_commit1),
    .pkt_drop(pkt_drop1), .drop_cnt(drop_cnt1));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pointers are plain integers mod 32; occupancy is their difference.
  typedef struct {
    int wr, cmt, cnt, s0, s1;
    bit in_pkt, disc, af;
  } model_t;

  typedef struct {
    int level, addr, gray, cnt;
    bit full, rdy, we, af, commit, drop;
  } exp_t;

  function automatic int to_gray(int b);
    return (b ^ (b >> 1)) & 31;
  endfunction

  function automatic int from_gray(int g);
    for (int b = 0; b < 32; b++) if (to_gray(b) == g) return b;
    return 0;
  endfunction

  function automatic exp_t predict(model_t m, bit d);
    exp_t e;
    bit acc;
    e.level  = (m.wr - from_gray(m.s1)) & 31;
    e.full   = (e.level == 16);
    e.rdy    = !e.full || m.disc || (m.in_pkt && d);
    acc      = s_valid && e.rdy;
    e.we     = acc && !e.full && !m.disc;
    e.commit = e.we && s_last && !s_user;
    e.drop   = (e.we && s_last && s_user) || (m.in_pkt && d && s_valid && e.full);
    e.addr   = m.wr & 15;
    e.gray   = to_gray(m.cmt);
    e.af     = m.af;
    e.cnt    = m.cnt;
    return e;
  endfunction

  function automatic model_t advance(model_t m, exp_t e);
    model_t n;
    n = m;
    if (reset) begin
      n = '{default: 0};
      return n;
    end
    n.s1 = m.s0;
    n.s0 = int'(rd_ptr_gray);
    n.af = ((16 - e.level) <= int'(af_thresh));
    if (e.drop && m.cnt < 65535) n.cnt = m.cnt + 1;
    if (e.we) begin
      n.wr = (m.wr + 1) & 31;
      if (!s_last) n.in_pkt = 1;
      else begin
        n.in_pkt = 0;
        if (!s_user) n.cmt = n.wr;
        else n.wr = m.cmt;
      end
    end else if (e.drop) begin
      n.wr = m.cmt;
      n.in_pkt = 0;
      n.disc = !s_last;
    end else if (m.disc && s_valid && s_last) begin
      n.disc = 0;
    end
    return n;
  endfunction

  task automatic cmp_dut(input int id, input exp_t e, input logic [4:0] lvl, input logic fl,
                         input logic rdy, input logic we, input logic [3:0] addr,
                         input logic [4:0] gray, input logic af, input logic cm,
                         input logic dr, input logic [15:0] cnt);
    check($sformatf("d%0d_level", id), 32'(lvl), 32'(e.level));
    check($sformatf("d%0d_full", id), 32'(fl), 32'(e.full));
    check($sformatf("d%0d_s_ready", id), 32'(rdy), 32'(e.rdy));
    check($sformatf("d%0d_mem_we", id), 32'(we), 32'(e.we));
    check($sformatf("d%0d_w_addr", id), 32'(addr), 32'(e.addr));
    check($sformatf("d%0d_w_ptr_gray", id), 32'(gray), 32'(e.gray));
    check($sformatf("d%0d_almost_full", id), 32'(af), 32'(e.af));
    check($sformatf("d%0d_pkt_commit", id), 32'(cm), 32'(e.commit));
    check($sformatf("d%0d_pkt_drop", id), 32'(dr), 32'(e.drop));
    check($sformatf("d%0d_drop_cnt", id), 32'(cnt), 32'(e.cnt));
  endtask

  model_t m0 = '{default: 0};
  model_t m1 = '{default: 0};
  bit     mvalid = 0;
  bit     reader_on = 0;
  bit     full_seen = 0;

  // Compare both DUTs against the model mid-cycle, then step the model over the next edge.
  always @(negedge clk) begin : compare_p
    exp_t e0, e1;
    e0 = predict(m0, 1'b0);
    e1 = predict(m1, 1'b1);
    if (mvalid) begin
      cmp_dut(0, e0, level0, full0, s_ready0, mem_we0, w_addr0, w_ptr_gray0,
              almost_full0, pkt_commit0, pkt_drop0, drop_cnt0);
      cmp_dut(1, e1, level1, full1, s_ready1, mem_we1, w_addr1, w_ptr_gray1,
              almost_full1, pkt_commit1, pkt_drop1, drop_cnt1);
      if (reader_on && (full0 || full1)) full_seen = 1;
    end
    m0 = advance(m0, e0);
    m1 = advance(m1, e1);
    if (reset) mvalid = 1;
  end

  // ---------------- stimulus ----------------
  bit         sel = 1;
  logic       sn_we, sn_commit, sn_drop, sn_rdy;
  logic [3:0] sn_addr;

  task automatic send(input bit last, input bit user);
    bit ok;
    s_valid = 1'b1; s_last = last; s_user = user;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sel ? s_ready1 : s_ready0) begin ok = 1; break; end
    end
    sn_we     = sel ? mem_we1 : mem_we0;
    sn_addr   = sel ? w_addr1 : w_addr0;
    sn_commit = sel ? pkt_commit1 : pkt_commit0;
    sn_drop   = sel ? pkt_drop1 : pkt_drop0;
    sn_rdy    = sel ? s_ready1 : s_ready0;
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0; s_last = 1'b0; s_user = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_user = 1'b0; rd_ptr_gray = 5'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    int we_cnt;
    do_reset();
    check("rst_s_ready", 32'(s_ready1), 32'd1);
    check("rst_level", 32'(level1), 32'd0);
    check("rst_w_ptr_gray", 32'(w_ptr_gray1), 32'd0);

    // 1: five-word good packet.
    sel = 1;
    for (int i = 0; i < 5; i++) begin
      send(i == 4, 1'b0);
      check($sformatf("t1_we%0d", i), 32'(sn_we), 32'd1);
      check($sformatf("t1_addr%0d", i), 32'(sn_addr), 32'(i));
      check($sformatf("t1_commit%0d", i), 32'(sn_commit), 32'(i == 4));
    end
    check("t1_w_ptr_gray", 32'(w_ptr_gray1), 32'b00111);

    // 2: three-word bad packet rewinds to address 5.
    for (int i = 0; i < 3; i++) begin
      send(i == 2, i == 2);
      check($sformatf("t2_addr%0d", i), 32'(sn_addr), 32'(5 + i));
      check($sformatf("t2_drop%0d", i), 32'(sn_drop), 32'(i == 2));
    end
    idle(1);
    check("t2_drop_cnt", 32'(drop_cnt1), 32'd1);
    check("t2_w_ptr_gray", 32'(w_ptr_gray1), 32'b00111);
    send(1'b1, 1'b0);
    check("t2_next_addr", 32'(sn_addr), 32'd5);
    check("t2_next_commit", 32'(sn_commit), 32'd1);
    idle(1);

    // 3: 20-word packet overflows the dropping instance.
    do_reset();
    sel = 1; we_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      send(i == 20, 1'b0);
      if (sn_we) we_cnt++;
      if (i == 17) check("t3_drop17", 32'(sn_drop), 32'd1);
      if (i >= 18) begin
        check($sformatf("t3_rdy%0d", i), 32'(sn_rdy), 32'd1);
        check($sformatf("t3_we%0d", i), 32'(sn_we), 32'd0);
      end
    end
    check("t3_we_count", 32'(we_cnt), 32'd16);
    idle(1);
    check("t3_level", 32'(level1), 32'd0);
    send(1'b1, 1'b0);
    check("t3_idle_addr", 32'(sn_addr), 32'd0);
    check("t3_idle_commit", 32'(sn_commit), 32'd1);
    idle(1);

    // 4: backpressuring instance fills with 16 committed words.
    do_reset();
    sel = 0;
    for (int p = 0; p < 4; p++)
      for (int i = 0; i < 4; i++) send(i == 3, 1'b0);
    idle(1);
    check("t4_full", 32'(full0), 32'd1);
    check("t4_s_ready", 32'(s_ready0), 32'd0);
    check("t4_level16", 32'(level0), 32'd16);
    rd_ptr_gray = 5'b00001;
    idle(1);
    check("t4_full_1cyc", 32'(full0), 32'd1);
    idle(1);
    check("t4_full_2cyc", 32'(full0), 32'd0);
    check("t4_level15", 32'(level0), 32'd15);

    // 5: almost_full at threshold 4.
    do_reset();
    sel = 1; af_thresh = 5'd4;
    for (int i = 0; i < 12; i++) send(i == 11, 1'b0);
    check("t5_level12", 32'(level1), 32'd12);
    check("t5_af_lag", 32'(almost_full1), 32'd0);
    idle(1);
    check("t5_af_set", 32'(almost_full1), 32'd1);
    rd_ptr_gray = 5'b00001;
    idle(2);
    check("t5_level11", 32'(level1), 32'd11);
    idle(1);
    check("t5_af_clr", 32'(almost_full1), 32'd0);
    af_thresh = 5'd0;

    // 6: 40 three-word packets with the reader following the committed pointer.
    do_reset();
    sel = 1; reader_on = 1;
    for (int p = 0; p < 40; p++)
      for (int i = 0; i < 3; i++) begin
        send(i == 2, 1'b0);
        rd_ptr_gray = w_ptr_gray1;
      end
    check("t6_w_ptr_gray", 32'(w_ptr_gray1), 32'b10100);
    idle(4);
    reader_on = 0;
    check("t6_no_full", 32'(full_seen), 32'd0);
    check("t6_level0", 32'(level1), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
